// File: rtl/vga_timing_decoder.sv
// VGA timing sink: recovers pixel coordinates from hs/vs/blank_n, measures line
// period and frame length, and locks once consecutive frames match nominal timing.
module vga_timing_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank_n,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       pix_valid,
    output logic [9:0] h_period,
    output logic [9:0] v_lines,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [9:0] H_ACT_10  = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOT_10  = 10'(H_TOTAL);
    localparam logic [9:0] V_ACT_10  = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT_10  = 10'(V_TOTAL);
    localparam logic [7:0] LOCK_8    = 8'(LOCK_FRAMES);
    localparam int         WD_LIMIT  = 2 * V_TOTAL * H_TOTAL;
    localparam int         WD_W      = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    state_t          state;
    logic            hs_q, vs_q, blank_q;
    logic [9:0]      hcnt, xcnt, ycnt, vline;
    logic            frame_ok;
    logic [7:0]      good;
    logic [WD_W-1:0] wd;

    logic       hs_fall, vs_fall, blank_fall;
    logic [9:0] h_meas, vline_eff, ycnt_eff;
    logic       line_bad, frame_good, wd_trip;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    always_comb begin
        hs_fall    = hs_q & ~vga_hs;
        vs_fall    = vs_q & ~vga_vs;
        blank_fall = blank_q & ~vga_blank_n;
        h_meas     = sat_inc(hcnt);
        line_bad   = (hs_fall && (h_meas != H_TOT_10)) ||
                     (blank_fall && (xcnt != H_ACT_10));
        // Same-cycle line/row events belong to the frame that is ending.
        vline_eff  = hs_fall ? sat_inc(vline) : vline;
        ycnt_eff   = blank_fall ? sat_inc(ycnt) : ycnt;
        frame_good = frame_ok && !line_bad &&
                     (vline_eff == V_TOT_10) && (ycnt_eff == V_ACT_10);
        wd_trip    = (state != SEARCH) && !vs_fall && (wd == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            hcnt        <= '0;
            xcnt        <= '0;
            ycnt        <= '0;
            vline       <= '0;
            frame_ok    <= 1'b0;
            good        <= '0;
            wd          <= '0;
            posx        <= '0;
            posy        <= '0;
            pix_valid   <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            hs_q        <= vga_hs;
            vs_q        <= vga_vs;
            blank_q     <= vga_blank_n;
            hcnt        <= hs_fall ? 10'd0 : h_meas;
            posy        <= ycnt;
            pix_valid   <= vga_blank_n & locked;
            frame_start <= vs_fall;
            timing_err  <= 1'b0;

            if (hs_fall) h_period <= h_meas;

            if (vga_blank_n) begin
                posx <= xcnt;
                xcnt <= sat_inc(xcnt);
            end else begin
                xcnt <= '0;
            end

            if (vs_fall) begin
                v_lines <= vline_eff;
                vline   <= '0;
                ycnt    <= '0;
                wd      <= '0;
            end else begin
                vline <= vline_eff;
                ycnt  <= ycnt_eff;
                wd    <= (state == SEARCH || wd_trip) ? '0 : wd + WD_W'(1);
            end

            if (state == SEARCH || line_bad) frame_ok <= 1'b0;

            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state    <= CHECK;
                        good     <= '0;
                        frame_ok <= 1'b1;
                    end
                end
                CHECK: begin
                    if (vs_fall) begin
                        frame_ok <= 1'b1;
                        if (frame_good) begin
                            good <= good + 8'd1;
                            if (good + 8'd1 == LOCK_8) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (wd_trip) begin
                        state    <= SEARCH;
                        frame_ok <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (vs_fall && frame_good) begin
                        frame_ok <= 1'b1;
                    end else if (vs_fall || wd_trip) begin
                        // Bad frame or lost vsync: drop lock and flag it once.
                        state      <= SEARCH;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                        frame_ok   <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
